// File: rtl/negate_pkg.sv
// Shared constants and helpers for the negate arbiter: default sizes,
// counter width, and a ceiling-log2 used to size the requester tag.
package negate_pkg;

   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 32;
   localparam int CNT_W    = 16;

   // Tag width for n requesters; never narrower than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) r++;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/negate_arbiter_cond_negate.sv
// Conditional two's-complement: passes d through when s=0, returns -d mod 2^W
// when s=1. The most negative value maps to itself.
module cond_negate
   import negate_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] d,
   input  logic         s,
   output logic [W-1:0] res
);

   assign res = (d ^ {W{s}}) + W'(s);

endmodule

// File: rtl/negate_arbiter.sv
// Round-robin share of one sign-apply unit between NREQ requesters; the
// selected result is registered with its source tag behind a valid/ready port.
module negate_arbiter
   import negate_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = clog2(NREQ),
   parameter int W    = W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_data,
   input  logic [NREQ-1:0]   req_sign,
   output logic [NREQ-1:0]   req_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [IDW-1:0]    out_id,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  conv_count
);

   localparam logic [IDW:0]   NREQ_X   = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic [IDW-1:0]   out_id_q, out_id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [IDW-1:0]   rot_idx [NREQ];
   logic [NREQ-1:0]  rot_valid;
   logic [IDW-1:0]   off;
   logic [IDW-1:0]   gnt;
   logic             any_valid;
   logic             can_load;
   logic             load;
   logic [W-1:0]     sel_data;
   logic             sel_sign;
   logic [W-1:0]     neg_res;

   // Slot g of the rotated view is requester (ptr+g) mod NREQ, so the
   // lowest set slot is the first valid requester at or after ptr.
   for (genvar g = 0; g < NREQ; g++) begin : g_rot
      logic [IDW:0] sum;
      assign sum          = {1'b0, ptr_q} + (IDW+1)'(g);
      assign rot_idx[g]   = (sum >= NREQ_X) ? IDW'(sum - NREQ_X) : IDW'(sum);
      assign rot_valid[g] = req_valid[rot_idx[g]];
   end

   always_comb begin
      off = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot_valid[i]) off = IDW'(i);
      end
   end

   assign gnt       = rot_idx[off];
   assign any_valid = |req_valid;
   assign can_load  = !out_valid_q || out_ready;
   assign load      = can_load && any_valid;

   // Gated by rst_n so no requester sees a handshake while reset is held.
   assign req_ready = (rst_n && load) ? (NREQ'(1) << gnt) : '0;

   assign sel_data = req_data[int'(gnt)*W +: W];
   assign sel_sign = req_sign[gnt];

   cond_negate #(.W(W)) u_cond_negate (
      .d   (sel_data),
      .s   (sel_sign),
      .res (neg_res)
   );

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      cnt_d       = cnt_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = neg_res;
         out_id_d    = gnt;
         ptr_d       = (gnt == LAST_IDX) ? '0 : gnt + IDW'(1);
         cnt_d       = cnt_q + CNT_W'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         cnt_q       <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_id     = out_id_q;
   assign conv_count = cnt_q;

endmodule

// File: tb/tb_negate_arbiter.sv
// Directed bench for negate_arbiter: a behavioural reference checked every
// cycle, plus literal expectations at the interesting points.
module tb_negate_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int W    = 32;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_sign;
   logic [NREQ-1:0]   req_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [IDW-1:0]    out_id;
   logic              out_ready;
   logic [15:0]       conv_count;

   int n_tests = 0;
   int n_fail  = 0;

   negate_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_sign   (req_sign),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_id     (out_id),
      .out_ready  (out_ready),
      .conv_count (conv_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: rotation position, output register and count.
   int          m_ptr;
   bit          m_valid;
   logic [31:0] m_data;
   int          m_id;
   int          m_cnt;

   function automatic int model_gnt();
      for (int k = 0; k < NREQ; k++) begin
         if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_cnt = 0;
      end else begin
         int g;
         g = model_gnt();
         if ((!m_valid || out_ready) && g >= 0) begin
            logic [31:0] d;
            d       = req_data[g*W +: W];
            m_data  = req_sign[g] ? 32'(0 - d) : d;
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % NREQ;
            m_cnt   = (m_cnt + 1) % 65536;
         end else if (out_ready) begin
            m_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      logic [NREQ-1:0] exp_ready;
      int g;
      exp_ready = '0;
      g = model_gnt();
      if (rst_n && (!m_valid || out_ready) && g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", out_data, m_data);
      check("out_id", 32'(out_id), 32'(m_id));
      check("conv_count", 32'(conv_count), 32'(m_cnt));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-shot request from requester idx; checks grant and registered result.
   task automatic single(input int idx, input logic [31:0] d, input logic s,
                         input logic [31:0] exp_res, input int exp_cnt);
      req_valid          = '0;
      req_valid[idx]     = 1'b1;
      req_data[idx*W +: W] = d;
      req_sign[idx]      = s;
      #2;
      check("single_ready", 32'(req_ready), 32'(1 << idx));
      tick();
      check("single_data", out_data, exp_res);
      check("single_id", 32'(out_id), 32'(idx));
      check("single_cnt", 32'(conv_count), 32'(exp_cnt));
      req_valid = '0;
      tick();
   endtask

   int          seq [6] = '{0, 1, 2, 3, 0, 1};
   logic [31:0] held;

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_sign  = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle after reset.
      repeat (10) tick();
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_ready", 32'(req_ready), 32'd0);
      check("idle_cnt", 32'(conv_count), 32'd0);

      // Single requester, both signs; leaves ptr at 3.
      single(2, 32'h0000_0005, 1'b1, 32'hFFFF_FFFB, 1);
      single(2, 32'h0000_0005, 1'b0, 32'h0000_0005, 2);

      // Edge values through requester 3; ptr settles at 0.
      single(3, 32'h8000_0000, 1'b1, 32'h8000_0000, 3);
      single(3, 32'h0000_0000, 1'b1, 32'h0000_0000, 4);
      single(3, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 5);

      // All requesters valid: strict rotation, one word per cycle.
      for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 32'h100 + 32'(i);
      req_sign  = 4'b1010;
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         #2;
         check("rr_ready", 32'(req_ready), 32'(1 << seq[k]));
         tick();
         check("rr_id", 32'(out_id), 32'(seq[k]));
         check("rr_cnt", 32'(conv_count), 32'(6 + k));
      end
      check("rr_data_req1", out_data, 32'hFFFF_FEFF);

      // Backpressure: register and rotation freeze.
      out_ready = 1'b0;
      held      = out_data;
      for (int k = 0; k < 3; k++) begin
         #2;
         check("stall_ready", 32'(req_ready), 32'd0);
         tick();
         check("stall_data", out_data, held);
         check("stall_id", 32'(out_id), 32'd1);
         check("stall_cnt", 32'(conv_count), 32'd11);
      end
      out_ready = 1'b1;
      #2;
      check("resume_ready", 32'(req_ready), 32'b0100);
      tick();
      check("resume_id", 32'(out_id), 32'd2);
      check("resume_data", out_data, 32'h0000_0102);
      tick();
      check("resume_id2", 32'(out_id), 32'd3);

      // Asynchronous reset between edges with out_valid=1.
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_data", out_data, 32'd0);
      check("arst_id", 32'(out_id), 32'd0);
      check("arst_cnt", 32'(conv_count), 32'd0);
      check("arst_ready", 32'(req_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      #2;
      check("post_ready", 32'(req_ready), 32'b0001);
      tick();
      check("post_id", 32'(out_id), 32'd0);
      check("post_cnt", 32'(conv_count), 32'd1);
      req_valid = '0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/negate_arbiter.md
Name: negate_arbiter

Overview:
- Shares one 32-bit conditional two's-complement (sign-apply) unit between NREQ requesters, e.g. systolic-array row drains.
- Each requester presents a 32-bit magnitude word and a sign bit. A round-robin arbiter picks one requester per cycle.
- The selected word is negated when its sign is 1. The result is registered with a requester tag and leaves on a valid/ready output.
- The block sits between the array accumulators and the result writeback path.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, tag width; must equal clog2(NREQ), minimum 1.
- W, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; deasserted synchronously to clk upstream.
- req_valid  input  NREQ  per-requester valid.
- req_data  input  NREQ*W  packed magnitudes; requester i occupies bits [i*W +: W].
- req_sign  input  NREQ  per-requester sign; 1 = negate.
- req_ready  output  NREQ  one-hot; indicates the requester's word is consumed this cycle.
- out_valid  output  1  result register holds a word.
- out_data  output  W  conditionally negated word.
- out_id  output  IDW  index of the source requester.
- out_ready  input  1  downstream accept.
- conv_count  output  16  number of accepted transfers; wraps modulo 2^16.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - out_valid=0, out_data=0, out_id=0, conv_count=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while rst_n is low.
  - A transfer in flight at reset is dropped.
- Datapath (combinational):
  - res = (d XOR {W{s}}) + s, mod 2^W.
  - d=0, s=1 gives 0.
  - d=0x80000000, s=1 gives 0x80000000; no saturation, no overflow flag.
- Accept condition: can_load = !out_valid | out_ready.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, ascending, wrapping at NREQ-1 -> 0.
  - The first set index is gnt.
  - req_ready[gnt] = can_load & (any req_valid). All other req_ready bits are 0.
  - req_ready must not depend combinationally on req_data or req_sign.
- Load on a clock edge with can_load & any req_valid:
  - out_data <= res(gnt).
  - out_id <= gnt.
  - out_valid <= 1.
  - ptr <= (gnt+1) mod NREQ.
  - conv_count <= conv_count+1.
- Drain:
  - out_valid & out_ready with no new request: out_valid <= 0. out_data and out_id hold their last values.
  - Simultaneous drain and load: the new word replaces the old one in the same cycle, giving full throughput of 1 word/cycle.
- Stall:
  - out_valid & !out_ready: the register holds, req_ready=0, and ptr is unchanged.
  - Requesters must hold valid, data and sign stable until they see req_ready (AXI-style).
- Latency: 1 cycle from req_ready to out_valid.
- Fairness: a continuously valid requester is granted within NREQ accepted transfers.
- ptr changes only on a load; idle cycles keep the rotation position.

Decomposition:
- Shared package negate_pkg holds:
  - NREQ_DEF=4, W_DEF=32.
  - CNT_W=16.
  - function clog2.
- One combinational sub-module, cond_negate: inputs d[W-1:0] and s; output res.
  - It is instantiated once, after the data mux. Do not instantiate it per requester.
- The arbiter (rotate, priority-encode, unrotate) is a generate loop inside negate_arbiter. It is not a separate module.

Test Plan:
1. Reset release, no requests: out_valid=0, req_ready=0000, conv_count=0 for 10 cycles.
2. Single requester: req2 with data=0x00000005, sign=1, out_ready=1.
   - Expect req_ready=0100 in cycle 0.
   - Next cycle: out_data=0xFFFFFFFB, out_id=2, conv_count=1.
   - Repeat with sign=0: out_data=0x00000005.
3. All 4 requesters valid continuously, out_ready=1:
   - Grants follow 0,1,2,3,0,1 on consecutive cycles.
   - conv_count increments by 1 per cycle.
4. Backpressure:
   - out_ready=0 for 3 cycles while out_valid=1: out_data stable, req_ready=0000, ptr frozen.
   - Raise out_ready: the next grant is the requester following the last one granted.
5. Edge values:
   - data=0x80000000, sign=1 -> 0x80000000.
   - data=0, sign=1 -> 0.
   - data=0xFFFFFFFF, sign=1 -> 0x00000001.
6. Reset mid-stream: assert rst_n low between clock edges while out_valid=1.
   - Outputs clear immediately, without waiting for a clock edge.
   - After release, the first grant goes to the lowest valid index (ptr=0), and conv_count restarts from 0.
